// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bundle for instr_encoder_loader.
// slave is the encoder side; master is the side that issues requests and models memory.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic              last;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [11:0]       imm;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              done;
    logic [15:0]       count;
    logic              err;

    modport slave (
        input  in_valid, op_sel, last, rd, rs1, rs2, imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_data, done, count, err
    );

    modport master (
        output in_valid, op_sel, last, rd, rs1, rs2, imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_data, done, count, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RV32 instruction requests, buffers them in a FWFT FIFO and writes them to instruction memory.
// Optional macro ENCODER_ILLEGAL_DROP_EN: illegal ops are dropped instead of being written as NOP.
module instr_encoder_loader #(
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h0000_0000)
) (
    input logic                  clk_i,
    input logic                  rst_i,
    instr_encoder_loader_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [31:0] encode_instr(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic [12:0] off;
        logic [31:0] word;
        off = {imm, 1'b0};
        case (op)
            4'd0:    word = 32'h0000_0013;
            4'd1:    word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd2:    word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd3:    word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            4'd4:    word = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
            4'd5:    word = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
            4'd6:    word = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd7:    word = {imm, rs1, 3'b000, rd, 7'b0010011};
            4'd8:    word = {7'b0100000, imm[4:0], rs1, 3'b101, rd, 7'b0010011};
            4'd9:    word = {imm, rs1, 3'b010, rd, 7'b0000011};
            4'd10:   word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            4'd11:   word = {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
            default: word = 32'h0000_0013;
        endcase
        return word;
    endfunction

    state_t            state_r;
    logic [31:0]       fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              in_ready_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       count_r;
    logic              done_r;
    logic              err_r;

    logic              accept_s;
    logic              illegal_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [31:0]       enc_s;

    assign accept_s   = bus.in_valid && in_ready_r;
    assign illegal_s  = (bus.op_sel[3:2] == 2'b11);
`ifdef ENCODER_ILLEGAL_DROP_EN
    assign push_s     = accept_s && !illegal_s;
`else
    assign push_s     = accept_s;
`endif
    assign pop_s      = mem_we_r && bus.mem_ready;
    assign cnt_next_s = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    assign enc_s      = encode_instr(bus.op_sel, bus.rd, bus.rs1, bus.rs2, bus.imm);

    // FIFO storage: contents need no reset since mem_we_r qualifies the head.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= enc_s;
        end
    end

    // Control FSM, FIFO pointers and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_LOAD;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            addr_r     <= BASE_ADDR;
            count_r    <= 16'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                addr_r   <= addr_r + ADDR_W'(4);
                count_r  <= count_r + 16'd1;
            end
            cnt_r    <= cnt_next_s;
            mem_we_r <= (cnt_next_s != {CNT_W{1'b0}});
            if (accept_s && illegal_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_LOAD: begin
                    done_r <= 1'b0;
                    if (accept_s && bus.last) begin
                        state_r    <= ST_DRAIN;
                        in_ready_r <= 1'b0;
                    end else begin
                        in_ready_r <= (cnt_next_s < CNT_W'(FIFO_DEPTH));
                    end
                end
                ST_DRAIN: begin
                    in_ready_r <= 1'b0;
                    // Also covers a last request that was dropped with the FIFO already empty.
                    if (cnt_next_s == {CNT_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_LOAD;
                    done_r     <= 1'b0;
                    addr_r     <= BASE_ADDR;
                    count_r    <= 16'd0;
                    in_ready_r <= (cnt_next_s < CNT_W'(FIFO_DEPTH));
                end
                default: begin
                    state_r    <= ST_LOAD;
                    done_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.mem_addr = addr_r;
    assign bus.mem_data = mem_we_r ? fifo_r[rd_ptr_r] : 32'h0000_0000;
    assign bus.done     = done_r;
    assign bus.count    = count_r;
    assign bus.err      = err_r;
endmodule
